// File: rtl/viterbi_tb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_tb_scheduler
//  Purpose  : Sequences the Viterbi survivor memory ring and the traceback
//             decoder. ACS survivor columns fill fixed-length pages. A full
//             page, or a partial page flushed at frame end, is handed to the
//             traceback decoder with a start/done handshake. ACS is
//             back-pressured while every page awaits traceback.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            system clock
//    reset          asynchronous active-high reset
//    i_acs_valid    ACS presents one survivor column this cycle
//    o_acs_ready    scheduler accepts a column this cycle
//    i_frame_end    last column of frame (qualifies a same-cycle write)
//    o_sm_we        survivor memory write enable
//    o_sm_wr_addr   survivor memory write address {page, column}
//    o_tb_start     one-cycle traceback start pulse
//    o_tb_page      page under traceback
//    o_tb_len       last valid column of that page
//    o_tb_last      page is the final page of its frame
//    i_tb_done      one-cycle pulse: traceback of o_tb_page finished
//    o_frame_done   one-cycle pulse: traceback of the frame's last page done
//    o_pend_cnt     pages complete and not yet traced back
//    o_overflow_err sticky: column offered while not ready
// ============================================================================
module viterbi_tb_scheduler #(
   parameter int DEPTH = 64,
   parameter int PAGES = 4,
   parameter int AW    = 6,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_acs_valid,
   output logic             o_acs_ready,
   input  logic             i_frame_end,
   output logic             o_sm_we,
   output logic [PW+AW-1:0] o_sm_wr_addr,
   output logic             o_tb_start,
   output logic [PW-1:0]    o_tb_page,
   output logic [AW-1:0]    o_tb_len,
   output logic             o_tb_last,
   input  logic             i_tb_done,
   output logic             o_frame_done,
   output logic [PW:0]      o_pend_cnt,
   output logic             o_overflow_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   localparam logic [PW:0]   c_PAGES_CNT = (PW+1)'(PAGES);
   localparam logic [PW:0]   c_PEND_ONE  = (PW+1)'(1);
   localparam logic [AW-1:0] c_COL_LAST  = AW'(DEPTH-1);
   localparam logic [AW-1:0] c_COL_ONE   = AW'(1);
   localparam logic [PW-1:0] c_PAGE_ONE  = PW'(1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [AW-1:0]             r_wr_col;
   logic [PW-1:0]             r_wr_page;
   logic [PW-1:0]             r_rd_page;
   logic [PW:0]               r_pend_cnt;
   logic [PAGES-1:0][AW-1:0]  r_len;
   logic [PAGES-1:0]          r_last;
   logic                      r_ovf;
   logic                      r_fd_flush;

   logic                      w_ready;
   logic                      w_we;
   logic                      w_fin;
   logic                      w_tb_start;
   logic                      w_close;
   logic [AW-1:0]             w_close_len;
   logic                      w_close_last;
   logic                      w_col_inc;
   logic                      w_mark;
   logic                      w_flush_empty;
   logic [PW-1:0]             w_prev_page;

   // When the ring is full, wr_page has wrapped onto rd_page with column 0,
   // so refusing writes here also protects the page under traceback.
   assign w_ready     = (r_pend_cnt < c_PAGES_CNT);
   assign w_we        = i_acs_valid & w_ready;
   assign w_fin       = (r_state == S_BUSY) & i_tb_done;
   assign w_prev_page = r_wr_page - c_PAGE_ONE;

   // Write-side decode: page close, column advance, or frame-end marking.
   always_comb begin
      w_close       = 1'b0;
      w_close_len   = r_wr_col;
      w_close_last  = 1'b0;
      w_col_inc     = 1'b0;
      w_mark        = 1'b0;
      w_flush_empty = 1'b0;
      if (w_we) begin
         if (i_frame_end) begin
            w_close      = 1'b1;
            w_close_last = 1'b1;
         end else if (r_wr_col == c_COL_LAST) begin
            w_close = 1'b1;
         end else begin
            w_col_inc = 1'b1;
         end
      end else if (i_frame_end) begin
         if (r_wr_col != '0) begin
            // Previous cycle's write was the frame's last column.
            w_close      = 1'b1;
            w_close_len  = r_wr_col - c_COL_ONE;
            w_close_last = 1'b1;
         end else if (r_pend_cnt > {{PW{1'b0}}, w_fin}) begin
            // Most recent page is still awaiting (or under) traceback and
            // is not retiring this very cycle: tag it as the frame's last.
            w_mark = 1'b1;
         end else begin
            // Nothing left to trace: report frame completion directly.
            w_flush_empty = 1'b1;
         end
      end
   end

   // Traceback FSM: next state and start pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_tb_start  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_cnt != '0) w_state_nxt = S_START;
         end
         S_START: begin
            w_tb_start  = 1'b1;
            w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (i_tb_done) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_col   <= '0;
         r_wr_page  <= '0;
         r_rd_page  <= '0;
         r_pend_cnt <= '0;
         r_len      <= '0;
         r_last     <= '0;
         r_ovf      <= 1'b0;
         r_fd_flush <= 1'b0;
      end else begin
         if (w_col_inc) begin
            r_wr_col <= r_wr_col + c_COL_ONE;
         end
         if (w_close) begin
            r_len[r_wr_page]  <= w_close_len;
            r_last[r_wr_page] <= w_close_last;
            r_wr_col          <= '0;
            r_wr_page         <= r_wr_page + c_PAGE_ONE;
         end
         if (w_mark) begin
            r_last[w_prev_page] <= 1'b1;
         end
         if (w_fin) begin
            r_rd_page <= r_rd_page + c_PAGE_ONE;
         end
         // A close and a retire in the same cycle cancel out.
         case ({w_close, w_fin})
            2'b10:   r_pend_cnt <= r_pend_cnt + c_PEND_ONE;
            2'b01:   r_pend_cnt <= r_pend_cnt - c_PEND_ONE;
            default: r_pend_cnt <= r_pend_cnt;
         endcase
         r_ovf      <= r_ovf | (i_acs_valid & ~w_ready);
         r_fd_flush <= w_flush_empty;
      end
   end

   assign o_acs_ready    = w_ready;
   assign o_sm_we        = w_we;
   assign o_sm_wr_addr   = {r_wr_page, r_wr_col};
   assign o_tb_start     = w_tb_start;
   // Page descriptors are stable while a page is pending; tb_last follows a
   // late frame-end mark applied to the page under traceback.
   assign o_tb_page      = r_rd_page;
   assign o_tb_len       = r_len[r_rd_page];
   assign o_tb_last      = r_last[r_rd_page];
   assign o_frame_done   = (w_fin & r_last[r_rd_page]) | r_fd_flush;
   assign o_pend_cnt     = r_pend_cnt;
   assign o_overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_tb_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_viterbi_tb_scheduler
//  Purpose  : Self-checking bench for viterbi_tb_scheduler. A cycle model
//             predicts traceback descriptors (queued at model START, popped
//             on DUT tb_start), frame_done, write addresses and counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_tb_scheduler;
   localparam int DEPTH = 64;
   localparam int PAGES = 4;
   localparam int AW    = 6;
   localparam int PW    = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             acs_valid = 1'b0;
   logic             frame_end = 1'b0;
   logic             tb_done;
   logic             o_acs_ready, o_sm_we, o_tb_start, o_tb_last;
   logic             o_frame_done, o_overflow_err;
   logic [PW+AW-1:0] o_sm_wr_addr;
   logic [PW-1:0]    o_tb_page;
   logic [AW-1:0]    o_tb_len;
   logic [PW:0]      o_pend_cnt;

   always #5 clk = ~clk;

   viterbi_tb_scheduler #(.DEPTH(DEPTH), .PAGES(PAGES), .AW(AW), .PW(PW)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_acs_valid    (acs_valid),
      .o_acs_ready    (o_acs_ready),
      .i_frame_end    (frame_end),
      .o_sm_we        (o_sm_we),
      .o_sm_wr_addr   (o_sm_wr_addr),
      .o_tb_start     (o_tb_start),
      .o_tb_page      (o_tb_page),
      .o_tb_len       (o_tb_len),
      .o_tb_last      (o_tb_last),
      .i_tb_done      (tb_done),
      .o_frame_done   (o_frame_done),
      .o_pend_cnt     (o_pend_cnt),
      .o_overflow_err (o_overflow_err)
   );

   typedef struct {int page; int len; bit last;} tbrec_t;
   typedef struct {int ncols; bit fe; int dly; int exp_starts; int exp_fd;} vec_t;

   tbrec_t exp_q[$];
   vec_t   vt[5];
   int     vec_cnt = 0;
   int     err_cnt = 0;

   // reference model state
   int m_col, m_page, m_rd, m_pend, m_st;
   bit m_last[PAGES];
   int m_len[PAGES];
   bit m_fd_flush, m_ovf;
   int cyc, close_cyc, first_start_cyc, n_starts, fd_cnt;

   // decoder model
   bit auto_mode = 1'b1;
   int dly = 1;
   int man_req = 0;
   int man_served;
   int dec_cnt;

   initial begin
      tb_done = 1'b0;
      dec_cnt = 0;
      man_served = 0;
      forever begin
         @(posedge clk);
         #2;
         tb_done = 1'b0;
         if (reset) begin
            dec_cnt = 0;
            man_served = man_req;
         end else if (auto_mode) begin
            if (dec_cnt > 0) begin
               dec_cnt--;
               if (dec_cnt == 0) tb_done = 1'b1;
            end else if (o_tb_start) begin
               dec_cnt = dly;
            end
         end else if (man_served != man_req) begin
            man_served++;
            tb_done = 1'b1;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Evaluated at the falling edge with this cycle's inputs stable.
   task automatic model_tick();
      bit ready, we, fin, close, close_last, mark, flush, exp_fd;
      int close_len;
      tbrec_t r;
      ready = (m_pend < PAGES);
      we    = acs_valid && ready;
      fin   = (m_st == 2) && tb_done;
      close = 0; close_last = 0; mark = 0; flush = 0; close_len = m_col;
      if (we) begin
         if (frame_end) begin close = 1; close_last = 1; end
         else if (m_col == DEPTH-1) close = 1;
      end else if (frame_end) begin
         if (m_col > 0) begin close = 1; close_len = m_col - 1; close_last = 1; end
         else if (m_pend > (fin ? 1 : 0)) mark = 1;
         else flush = 1;
      end
      if (m_st == 1) exp_q.push_back('{m_rd, m_len[m_rd], m_last[m_rd]});
      if (o_tb_start) begin
         if (n_starts == 0) first_start_cyc = cyc;
         n_starts++;
         if (exp_q.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL tb_start: unexpected pulse at cycle %0d, expected none", cyc);
         end else begin
            r = exp_q.pop_front();
            chk("tb_page", 32'(o_tb_page), r.page);
            chk("tb_len",  32'(o_tb_len),  r.len);
            chk("tb_last", 32'(o_tb_last), 32'(r.last));
         end
      end
      exp_fd = (fin && m_last[m_rd]) || m_fd_flush;
      if (exp_fd || o_frame_done) chk("frame_done", 32'(o_frame_done), 32'(exp_fd));
      if (o_frame_done) fd_cnt++;
      if (we || o_sm_we) begin
         chk("sm_we", 32'(o_sm_we), 32'(we));
         if (we) chk("sm_wr_addr", 32'(o_sm_wr_addr), m_page*DEPTH + m_col);
      end
      // advance model
      if (m_st == 0 && m_pend > 0) m_st = 1;
      else if (m_st == 1) m_st = 2;
      else if (fin) m_st = 0;
      if (we && !close) m_col++;
      if (close) begin
         m_len[m_page]  = close_len;
         m_last[m_page] = close_last;
         m_col  = 0;
         m_page = (m_page + 1) % PAGES;
         if (close_cyc < 0) close_cyc = cyc;
      end
      if (mark) m_last[(m_page + PAGES - 1) % PAGES] = 1;
      if (fin) m_rd = (m_rd + 1) % PAGES;
      m_pend = m_pend + (close ? 1 : 0) - (fin ? 1 : 0);
      m_ovf  = m_ovf || (acs_valid && !ready);
      m_fd_flush = flush;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      model_tick();
      @(posedge clk);
      #1;
      chk("pend_cnt",     32'(o_pend_cnt),     m_pend);
      chk("acs_ready",    32'(o_acs_ready),    32'(m_pend < PAGES));
      chk("overflow_err", 32'(o_overflow_err), 32'(m_ovf));
   endtask

   task automatic drive(bit v, bit fe);
      acs_valid = v;
      frame_end = fe;
      step();
   endtask

   task automatic check_reset_outputs();
      chk("rst acs_ready",  32'(o_acs_ready), 1);
      chk("rst sm_we",      32'(o_sm_we), 0);
      chk("rst sm_wr_addr", 32'(o_sm_wr_addr), 0);
      chk("rst tb_start",   32'(o_tb_start), 0);
      chk("rst tb_page",    32'(o_tb_page), 0);
      chk("rst tb_len",     32'(o_tb_len), 0);
      chk("rst tb_last",    32'(o_tb_last), 0);
      chk("rst frame_done", 32'(o_frame_done), 0);
      chk("rst pend_cnt",   32'(o_pend_cnt), 0);
      chk("rst overflow",   32'(o_overflow_err), 0);
   endtask

   task automatic do_reset();
      acs_valid = 1'b0;
      frame_end = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      m_col = 0; m_page = 0; m_rd = 0; m_pend = 0; m_st = 0;
      for (int i = 0; i < PAGES; i++) begin m_last[i] = 0; m_len[i] = 0; end
      m_fd_flush = 0; m_ovf = 0;
      exp_q.delete();
      cyc = 0; close_cyc = -1; first_start_cyc = -1; n_starts = 0; fd_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_drain(int budget);
      int n;
      n = 0;
      while ((m_pend != 0 || m_st != 0) && n < budget) begin
         drive(0, 0);
         n++;
      end
      if (n >= budget) begin
         vec_cnt++; err_cnt++;
         $display("FAIL drain: traceback not finished after %0d cycles, expected idle", budget);
      end
      drive(0, 0);
      drive(0, 0);
   endtask

   task automatic wait_starts(int target, int budget);
      int n;
      n = 0;
      while (n_starts < target && n < budget) begin
         drive(0, 0);
         n++;
      end
      if (n >= budget) begin
         vec_cnt++; err_cnt++;
         $display("FAIL wait_start: got %0d starts, expected %0d", n_starts, target);
      end
   endtask

   initial begin
      vt[0] = '{ncols: 64,  fe: 1'b0, dly: 70, exp_starts: 1, exp_fd: 0};
      vt[1] = '{ncols: 100, fe: 1'b1, dly: 5,  exp_starts: 2, exp_fd: 1};
      vt[2] = '{ncols: 1,   fe: 1'b1, dly: 3,  exp_starts: 1, exp_fd: 1};
      vt[3] = '{ncols: 128, fe: 1'b1, dly: 10, exp_starts: 2, exp_fd: 1};
      vt[4] = '{ncols: 200, fe: 1'b0, dly: 1,  exp_starts: 3, exp_fd: 0};

      // Table-driven bursts with an auto-responding decoder.
      for (int i = 0; i < 5; i++) begin
         auto_mode = 1'b1;
         dly = vt[i].dly;
         do_reset();
         for (int k = 0; k < vt[i].ncols; k++)
            drive(1'b1, vt[i].fe && (k == vt[i].ncols - 1));
         drive(0, 0);
         wait_drain(400);
         chk("row starts",   n_starts, vt[i].exp_starts);
         chk("row frames",   fd_cnt, vt[i].exp_fd);
         chk("row latency",  first_start_cyc - close_cyc, 2);
         chk("row pend",     32'(o_pend_cnt), 0);
         chk("row sb empty", exp_q.size(), 0);
      end

      // Ring full, overflow, resume after one traceback.
      auto_mode = 1'b0;
      do_reset();
      for (int k = 0; k < PAGES*DEPTH; k++) drive(1, 0);
      chk("full pend",  32'(o_pend_cnt), PAGES);
      chk("full ready", 32'(o_acs_ready), 0);
      drive(1, 0);
      chk("overflow set", 32'(o_overflow_err), 1);
      man_req++;
      drive(1, 0);
      chk("resume ready", 32'(o_acs_ready), 1);
      chk("resume we",    32'(o_sm_we), 1);
      chk("resume addr",  32'(o_sm_wr_addr), 0);
      drive(0, 0);
      chk("overflow sticky", 32'(o_overflow_err), 1);
      wait_starts(2, 10);
      chk("full sb empty", exp_q.size(), 0);

      // Page close in the same cycle as tb_done.
      auto_mode = 1'b0;
      do_reset();
      for (int k = 0; k < 2*DEPTH - 1; k++) drive(1, 0);
      chk("same pend before", 32'(o_pend_cnt), 1);
      man_req++;
      drive(1, 0);
      chk("same pend after", 32'(o_pend_cnt), 1);
      wait_starts(2, 10);
      chk("same next page", 32'(o_tb_page), 1);
      man_req++;
      drive(0, 0);
      wait_drain(20);
      chk("same sb empty", exp_q.size(), 0);

      // Frame end on a page boundary with that page still pending, then a
      // frame end with nothing pending.
      auto_mode = 1'b0;
      do_reset();
      for (int k = 0; k < DEPTH; k++) drive(1, 0);
      drive(0, 0);
      drive(0, 1);
      drive(0, 0);
      drive(0, 0);
      chk("mark tb_last", 32'(o_tb_last), 1);
      man_req++;
      drive(0, 0);
      chk("mark frame_done", fd_cnt, 1);
      wait_drain(20);
      drive(0, 1);
      drive(0, 0);
      chk("empty flush frame_done", fd_cnt, 2);
      chk("mark sb empty", exp_q.size(), 0);

      // Reset while busy with three pages pending.
      auto_mode = 1'b0;
      do_reset();
      for (int k = 0; k < 3*DEPTH; k++) drive(1, 0);
      drive(0, 0);
      chk("busy pend", 32'(o_pend_cnt), 3);
      do_reset();
      acs_valid = 1'b1;
      #1;
      chk("post-reset we",   32'(o_sm_we), 1);
      chk("post-reset addr", 32'(o_sm_wr_addr), 0);
      drive(1, 0);
      drive(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
`default_nettype wire
